// File: rtl/streaming_dwc_pack_if.sv
// Narrow-in / wide-out stream bundle for the width packer.
// The slave modport is the packer's view; the master modport is the surrounding fabric's view.
interface streaming_dwc_pack_if #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 32
);
    logic [IN_WIDTH-1:0]  in0_V_V_TDATA;
    logic                 in0_V_V_TVALID;
    logic                 in0_V_V_TREADY;
    logic [OUT_WIDTH-1:0] out_V_V_TDATA;
    logic                 out_V_V_TVALID;
    logic                 out_V_V_TREADY;

    modport slave (
        input  in0_V_V_TDATA,
        input  in0_V_V_TVALID,
        output in0_V_V_TREADY,
        output out_V_V_TDATA,
        output out_V_V_TVALID,
        input  out_V_V_TREADY
    );

    modport master (
        output in0_V_V_TDATA,
        output in0_V_V_TVALID,
        input  in0_V_V_TREADY,
        input  out_V_V_TDATA,
        input  out_V_V_TVALID,
        output out_V_V_TREADY
    );
endinterface

// File: rtl/streaming_dwc_pack.sv
// Frame-aware narrow-to-wide stream packer: RATIO little-endian beats per output word,
// zero-padding the last word of a frame whose length is not a multiple of RATIO.
module streaming_dwc_pack #(
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned OUT_WIDTH      = 32,
    parameter int unsigned FRAME_IN_WORDS = 784,
    parameter int unsigned FCNT_WIDTH     = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    streaming_dwc_pack_if.slave    s,
    output logic [FCNT_WIDTH-1:0]  frame_cnt
);
    localparam int unsigned RATIO  = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned BEAT_W = (FRAME_IN_WORDS > 1) ? $clog2(FRAME_IN_WORDS) : 1;

    logic [OUT_WIDTH-1:0]  acc_q, acc_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;

    logic                  in_ready_c;
    logic                  accept_c;
    logic                  last_lane_c;
    logic                  last_beat_c;
    logic [OUT_WIDTH-1:0]  merged_c;

    // Single-word skid: input stalls only while a finished word is blocked downstream.
    assign in_ready_c  = !out_valid_q || s.out_V_V_TREADY;
    assign accept_c    = s.in0_V_V_TVALID && in_ready_c;
    assign last_lane_c = (lane_q == LANE_W'(RATIO - 1));
    assign last_beat_c = (beat_q == BEAT_W'(FRAME_IN_WORDS - 1));

    // Accumulator with the incoming beat dropped into the current lane; higher lanes stay 0.
    always_comb begin
        merged_c = acc_q;
        for (int k = 0; k < int'(RATIO); k++) begin
            if (lane_q == LANE_W'(k)) begin
                merged_c[k*IN_WIDTH +: IN_WIDTH] = s.in0_V_V_TDATA;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        lane_d      = lane_q;
        beat_d      = beat_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        fcnt_d      = fcnt_q;

        if (out_valid_q && s.out_V_V_TREADY) begin
            out_valid_d = 1'b0;
        end

        if (accept_c) begin
            if (last_lane_c || last_beat_c) begin
                out_data_d  = merged_c;
                out_valid_d = 1'b1;
                acc_d       = '0;
                lane_d      = '0;
            end else begin
                acc_d       = merged_c;
                lane_d      = lane_q + LANE_W'(1);
            end

            // Frame boundary also forces the word out above, so padding never spans frames.
            if (last_beat_c) begin
                beat_d = '0;
                fcnt_d = fcnt_q + FCNT_WIDTH'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            lane_q      <= '0;
            beat_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            acc_q       <= acc_d;
            lane_q      <= lane_d;
            beat_q      <= beat_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign s.in0_V_V_TREADY = in_ready_c;
    assign s.out_V_V_TDATA  = out_data_q;
    assign s.out_V_V_TVALID = out_valid_q;
    assign frame_cnt        = fcnt_q;
endmodule
